// File: rtl/shift_adder_acc.sv
// shift_adder_acc: pipelined add / subtract / accumulate unit.
//   Operands and mode pass through PIPE_REGS register stages. A registered
//   compute stage follows them and produces the result.
//   The carry or borrow goes into GUARD extra result bits. Overflow is sticky.
//   The ACC and ACC_SUB modes read the current result, so they accumulate.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   valid_in   in   qualifies mode/lefthand/righthand this cycle
//   mode       in   2'b00 ADD, 2'b01 SUB, 2'b10 ACC, 2'b11 ACC_SUB
//   lefthand   in   operand L (unsigned, WIDTH bits)
//   righthand  in   operand R (unsigned, WIDTH bits)
//   clear      in   synchronous clear of result, overflow and in-flight ops
//   result     out  registered result / accumulator (WIDTH+GUARD bits)
//   valid_out  out  one-cycle pulse when result was updated
//   overflow   out  sticky flag: some result was not representable
// Configuration macro:
//   SHIFT_ADDER_ACC_SAT_EN  when defined, an out-of-range result saturates
//                           (0 or all ones); otherwise it wraps.
module shift_adder_acc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GUARD     = 1,
  parameter int unsigned PIPE_REGS = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         lefthand,
  input  logic [WIDTH-1:0]         righthand,
  input  logic                     clear,
  output logic [WIDTH+GUARD-1:0]   result,
  output logic                     valid_out,
  output logic                     overflow
);

  localparam int unsigned RES_WIDTH = WIDTH + GUARD;
  // Two bits of headroom hold every exact value, including negative ones.
  // The largest is (2^RES_WIDTH-1) + 2*(2^WIDTH-1); the smallest is -(2^WIDTH-1).
  localparam int unsigned EXT_WIDTH = RES_WIDTH + 2;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;

  // Operation as seen by the compute stage
  logic             cmp_vld;
  logic [1:0]       cmp_mode;
  logic [WIDTH-1:0] cmp_l;
  logic [WIDTH-1:0] cmp_r;

  generate
    if (PIPE_REGS == 0) begin : g_nopipe
      assign cmp_vld  = valid_in;
      assign cmp_mode = mode;
      assign cmp_l    = lefthand;
      assign cmp_r    = righthand;
    end else begin : g_pipe
      logic [PIPE_REGS-1:0] vld_q, vld_d;
      logic [1:0]           mode_q [PIPE_REGS];
      logic [1:0]           mode_d [PIPE_REGS];
      logic [WIDTH-1:0]     l_q    [PIPE_REGS];
      logic [WIDTH-1:0]     l_d    [PIPE_REGS];
      logic [WIDTH-1:0]     r_q    [PIPE_REGS];
      logic [WIDTH-1:0]     r_d    [PIPE_REGS];

      // Operand shift chain. Clear kills only the valid bits; data is don't-care.
      always_comb begin
        vld_d     = '0;
        vld_d[0]  = valid_in & ~clear;
        mode_d[0] = mode;
        l_d[0]    = lefthand;
        r_d[0]    = righthand;
        for (int i = 1; i < int'(PIPE_REGS); i++) begin
          vld_d[i]  = vld_q[i-1] & ~clear;
          mode_d[i] = mode_q[i-1];
          l_d[i]    = l_q[i-1];
          r_d[i]    = r_q[i-1];
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
          for (int i = 0; i < int'(PIPE_REGS); i++) begin
            mode_q[i] <= '0;
            l_q[i]    <= '0;
            r_q[i]    <= '0;
          end
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < int'(PIPE_REGS); i++) begin
            mode_q[i] <= mode_d[i];
            l_q[i]    <= l_d[i];
            r_q[i]    <= r_d[i];
          end
        end
      end

      assign cmp_vld  = vld_q[PIPE_REGS-1];
      assign cmp_mode = mode_q[PIPE_REGS-1];
      assign cmp_l    = l_q[PIPE_REGS-1];
      assign cmp_r    = r_q[PIPE_REGS-1];
    end
  endgenerate

  logic [RES_WIDTH-1:0] result_q, result_d;
  logic                 valid_out_q, valid_out_d;
  logic                 overflow_q, overflow_d;

  logic [EXT_WIDTH-1:0] l_ext, r_ext, old_ext, sum_ext;
  logic                 over_c;
  logic [RES_WIDTH-1:0] res_val_c;

  // Exact arithmetic in two's complement, wide enough that nothing is lost
  always_comb begin
    l_ext   = EXT_WIDTH'(cmp_l);
    r_ext   = EXT_WIDTH'(cmp_r);
    old_ext = EXT_WIDTH'(result_q);
    unique case (cmp_mode)
      MODE_ADD: sum_ext = l_ext + r_ext;
      MODE_SUB: sum_ext = l_ext - r_ext;
      MODE_ACC: sum_ext = old_ext + l_ext + r_ext;
      default:  sum_ext = old_ext + l_ext - r_ext;
    endcase
    // The value is out of range if it is negative or at least 2^RES_WIDTH.
    over_c = |sum_ext[EXT_WIDTH-1:RES_WIDTH];
`ifdef SHIFT_ADDER_ACC_SAT_EN
    if (sum_ext[EXT_WIDTH-1]) begin
      res_val_c = '0;
    end else if (over_c) begin
      res_val_c = '1;
    end else begin
      res_val_c = sum_ext[RES_WIDTH-1:0];
    end
`else
    res_val_c = sum_ext[RES_WIDTH-1:0];
`endif
  end

  // Compute stage update; clear dominates a valid op
  always_comb begin
    result_d    = result_q;
    overflow_d  = overflow_q;
    valid_out_d = 1'b0;
    if (clear) begin
      result_d   = '0;
      overflow_d = 1'b0;
    end else if (cmp_vld) begin
      result_d    = res_val_c;
      overflow_d  = overflow_q | over_c;
      valid_out_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      result_q    <= result_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result    = result_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_shift_adder_acc.sv
// Directed test of shift_adder_acc (WIDTH=8, GUARD=1, PIPE_REGS=1).
// A reference model computes each result when the op is issued and queues it.
// The queued results are compared when the DUT shows them.
module tb_shift_adder_acc;

  localparam int LAT  = 2;
  localparam int RMAX = 511;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] ACC  = 2'b10;
  localparam logic [1:0] ACCS = 2'b11;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [1:0] mode;
  logic [7:0] lefthand;
  logic [7:0] righthand;
  logic       clear;
  logic [8:0] result;
  logic       valid_out;
  logic       overflow;

  shift_adder_acc #(.WIDTH(8), .GUARD(1), .PIPE_REGS(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (valid_in),
    .mode      (mode),
    .lefthand  (lefthand),
    .righthand (righthand),
    .clear     (clear),
    .result    (result),
    .valid_out (valid_out),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         due;
    logic [8:0] res;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   edge_n = 0;
  int   m_res = 0;      // model accumulator at issue time
  logic m_ovf = 1'b0;
  logic [8:0] o_res = '0; // expected visible outputs
  logic       o_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the model at the edge, then check outputs 1ns later.
  task automatic tick(input logic v, input logic [1:0] m, input int l, input int r,
                      input logic clr, input string tag);
    int   ex;
    exp_t it;
    valid_in  = v;
    mode      = m;
    lefthand  = 8'(l);
    righthand = 8'(r);
    clear     = clr;
    @(posedge clock);
    edge_n++;
    if (clr) begin
      sb.delete();
      m_res = 0; m_ovf = 1'b0; o_res = '0; o_ovf = 1'b0;
    end else if (v) begin
      case (m)
        ADD:     ex = l + r;
        SUB:     ex = l - r;
        ACC:     ex = m_res + l + r;
        default: ex = m_res + l - r;
      endcase
      if (ex < 0 || ex > RMAX) m_ovf = 1'b1;
`ifdef SHIFT_ADDER_ACC_SAT_EN
      m_res = (ex < 0) ? 0 : (ex > RMAX) ? RMAX : ex;
`else
      m_res = ex & RMAX;
`endif
      // Visible right after edge (issue edge + LAT - 1), i.e. LAT cycles after valid_in.
      sb.push_back('{edge_n + LAT - 1, 9'(m_res), m_ovf});
    end
    #1;
    if (sb.size() > 0 && sb[0].due == edge_n) begin
      it = sb.pop_front();
      o_res = it.res;
      o_ovf = it.ovf;
      chk({tag, " valid_out"}, 32'(valid_out), 32'd1);
      chk({tag, " result"}, 32'(result), 32'(o_res));
      chk({tag, " overflow"}, 32'(overflow), 32'(o_ovf));
    end else begin
      chk({tag, " idle valid_out"}, 32'(valid_out), 32'd0);
      chk({tag, " hold result"}, 32'(result), 32'(o_res));
      chk({tag, " hold overflow"}, 32'(overflow), 32'(o_ovf));
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, ADD, 0, 0, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; mode = ADD; lefthand = '0; righthand = '0; clear = 1'b0;
    #2;
    chk("reset result", 32'(result), 32'd0);
    chk("reset valid_out", 32'(valid_out), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    @(posedge clock);
    #3 reset = 1'b0;

    // 1: plain add into the guard bit
    tick(1'b1, ADD, 200, 100, 1'b0, "t1 issue");
    idle(3, "t1");
    chk("t1 value 300", 32'(result), 32'h12C);

    // Boundary: the largest add does not overflow
    tick(1'b1, ADD, 255, 255, 1'b0, "max add");
    idle(2, "max add");

    // 2: SUB underflow, then a clean ADD keeps the sticky overflow
    tick(1'b1, SUB, 5, 7, 1'b0, "t2 sub");
    idle(2, "t2");
    tick(1'b1, ADD, 1, 1, 1'b0, "sticky");
    idle(2, "sticky");

    // 3: clear, then back-to-back accumulation past the top
    tick(1'b0, ADD, 0, 0, 1'b1, "t3 clear");
    tick(1'b1, ACC, 255, 255, 1'b0, "t3 acc1");
    tick(1'b1, ACC, 255, 255, 1'b0, "t3 acc2");
    idle(2, "t3");

    // Accumulate-subtract below zero
    tick(1'b0, ADD, 0, 0, 1'b1, "neg clear");
    tick(1'b1, ACCS, 0, 5, 1'b0, "neg accsub");
    idle(2, "neg");

    // 4: four ops on consecutive cycles, with a dependent chain at full rate
    tick(1'b0, ADD, 0, 0, 1'b1, "t4 clear");
    tick(1'b1, ADD, 1, 2, 1'b0, "t4 op1");
    tick(1'b1, SUB, 9, 4, 1'b0, "t4 op2");
    tick(1'b1, ACC, 3, 3, 1'b0, "t4 op3");
    tick(1'b1, ACCS, 0, 1, 1'b0, "t4 op4");
    idle(2, "t4");
    chk("t4 final 10", 32'(result), 32'd10);

    // 5: clear together with the second issue drops both ops
    tick(1'b1, ADD, 7, 7, 1'b0, "t5 op1");
    tick(1'b1, ADD, 8, 8, 1'b1, "t5 op2+clear");
    idle(3, "t5");
    // Clear one cycle later: op1 has already completed, op2 is dropped
    tick(1'b1, ADD, 7, 7, 1'b0, "t5b op1");
    tick(1'b1, ADD, 8, 8, 1'b0, "t5b op2");
    tick(1'b0, ADD, 0, 0, 1'b1, "t5b clear");
    idle(2, "t5b");

    // 6: asynchronous reset between edges while an op is in flight
    tick(1'b1, ADD, 100, 100, 1'b0, "t6 pre");
    idle(2, "t6 pre");
    tick(1'b1, ADD, 50, 60, 1'b0, "t6 inflight");
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6 async result", 32'(result), 32'd0);
    chk("t6 async valid_out", 32'(valid_out), 32'd0);
    chk("t6 async overflow", 32'(overflow), 32'd0);
    sb.delete();
    m_res = 0; m_ovf = 1'b0; o_res = '0; o_ovf = 1'b0;
    @(posedge clock);
    edge_n++;
    #1;
    chk("t6 held valid_out", 32'(valid_out), 32'd0);
    #2 reset = 1'b0;
    tick(1'b1, ADD, 10, 20, 1'b0, "t6 post");
    idle(3, "t6 post");

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_mis++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
